// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants and types for the instruction-fetch stage
package if_stage_pkg;

  localparam int INST_LEN = 32;
  localparam int XLEN_DEFAULT = 64;

  typedef logic [INST_LEN-1:0] instr_t;

  localparam instr_t NOP = 32'h0000_0013;

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bundle: imem request/response, redirect, stall and decode outputs
interface if_stage_if
  import if_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic            stalln_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            imem_req_valid_o;
  logic            imem_req_ready_i;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_rsp_valid_i;
  instr_t          imem_rsp_data_i;
  logic            valid_o;
  logic [XLEN-1:0] pc_o;
  instr_t          instr_o;

  modport master (
    input  stalln_i, redirect_i, redirect_pc_i, imem_req_ready_i,
    input  imem_rsp_valid_i, imem_rsp_data_i,
    output imem_req_valid_o, imem_req_addr_o, valid_o, pc_o, instr_o
  );

  modport slave (
    output stalln_i, redirect_i, redirect_pc_i, imem_req_ready_i,
    output imem_rsp_valid_i, imem_rsp_data_i,
    input  imem_req_valid_o, imem_req_addr_o, valid_o, pc_o, instr_o
  );

endinterface

// File: rtl/if_stage_fetch_queue.sv
// rtl/if_stage_fetch_queue.sv - in-order instruction queue with allocate/fill/pop/flush and drop accounting
module fetch_queue
  import if_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            rsp_valid,
  input  instr_t          rsp_data,
  input  logic            stalln,
  output logic            can_alloc,
  output logic            valid,
  output logic [XLEN-1:0] head_pc,
  output instr_t          head_instr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Stale responses from several back-to-back redirects can stack up, so the
  // outstanding counters get headroom beyond a single queue's worth.
  localparam int OW = PW + 3;

  logic [PW-1:0]   head, tail, fill;
  logic [CW-1:0]   count;
  logic [OW-1:0]   inflight, drop;
  logic [DEPTH-1:0] full;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  instr_t          instr_mem [DEPTH];
  logic            pop, take;

  assign valid      = full[head];
  assign pop        = valid && stalln && !flush;
  assign take       = rsp_valid && (drop == '0) && !flush;
  assign can_alloc  = (count < CW'(DEPTH)) || pop;
  assign head_pc    = valid ? pc_mem[head] : '0;
  assign head_instr = valid ? instr_mem[head] : NOP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      count    <= '0;
      full     <= '0;
      inflight <= '0;
      drop     <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      count    <= '0;
      full     <= '0;
      inflight <= '0;
      // Everything still outstanding is stale; a response landing now is one of them.
      drop     <= drop + inflight - OW'(rsp_valid);
    end else begin
      if (pop) begin
        full[head] <= 1'b0;
        head       <= head + 1'b1;
      end
      if (alloc) begin
        full[tail] <= 1'b0;
        tail       <= tail + 1'b1;
      end
      if (take) begin
        full[fill] <= 1'b1;
        fill       <= fill + 1'b1;
      end
      if (rsp_valid && (drop != '0)) drop <= drop - 1'b1;
      count    <= count + CW'(alloc) - CW'(pop);
      inflight <= inflight + OW'(alloc) - OW'(take);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc && !flush) pc_mem[tail] <= alloc_pc;
    if (take) instr_mem[fill] <= rsp_data;
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: fetch PC, request issue and decode-facing queue
module if_stage
  import if_stage_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  if_stage_if.master bus
);

  logic [XLEN-1:0] fpc;
  logic            can_alloc, req_valid, accept;

  assign req_valid = !rst && !bus.redirect_i && can_alloc;
  assign accept    = req_valid && bus.imem_req_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc <= RESET_PC;
    end else if (bus.redirect_i) begin
      fpc <= {bus.redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (accept) begin
      fpc <= fpc + XLEN'(4);
    end
  end

  fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.redirect_i),
    .alloc      (accept),
    .alloc_pc   (fpc),
    .rsp_valid  (bus.imem_rsp_valid_i),
    .rsp_data   (bus.imem_rsp_data_i),
    .stalln     (bus.stalln_i),
    .can_alloc  (can_alloc),
    .valid      (bus.valid_o),
    .head_pc    (bus.pc_o),
    .head_instr (bus.instr_o)
  );

  assign bus.imem_req_valid_o = req_valid;
  assign bus.imem_req_addr_o  = fpc;

endmodule
